// File: rtl/rng_round_controller_if.sv
// rng_round_controller_if: game-FSM, generator, display and keypad signals of one round controller
interface rng_round_controller_if;
  logic       Start;
  logic [1:0] Level;
  logic       Tick;
  logic [3:0] RandIn;
  logic       RandEnable;
  logic [1:0] LevelOut;
  logic [3:0] ShowDigit;
  logic       ShowValid;
  logic [3:0] Guess;
  logic       GuessValid;
  logic       Busy;
  logic       Win;
  logic       Lose;
  logic [7:0] Score;
  modport master (
    output Start, Level, Tick, RandIn, Guess, GuessValid,
    input  RandEnable, LevelOut, ShowDigit, ShowValid, Busy, Win, Lose, Score
  );
  modport slave (
    input  Start, Level, Tick, RandIn, Guess, GuessValid,
    output RandEnable, LevelOut, ShowDigit, ShowValid, Busy, Win, Lose, Score
  );
endinterface

// File: rtl/rng_round_controller.sv
// rng_round_controller: captures, replays and checks a level-sized digit sequence, keeping a saturating score
module rng_round_controller #(
  parameter int SEQ_MAX     = 8,
  parameter int SHOW_TICKS  = 4,
  parameter int INPUT_TICKS = 16
) (
  input logic Clock,
  input logic Reset,
  rng_round_controller_if.slave bus
);
  localparam int IW = $clog2(SEQ_MAX);
  localparam int TW = $clog2(SHOW_TICKS + INPUT_TICKS);
  typedef enum logic [2:0] {IDLE, FILL, SHOW, INPUT, WIN, LOSE} state_t;
  state_t state;
  logic [3:0] digits [SEQ_MAX];
  logic [IW-1:0] idx, last;
  logic [TW-1:0] tcnt;
  logic [1:0] lvl;
  always_comb lvl = bus.Level[1] ? 2'd2 : bus.Level;
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      idx <= '0;
      last <= '0;
      tcnt <= '0;
      for (int i = 0; i < SEQ_MAX; i++) digits[i] <= '0;
      bus.RandEnable <= 1'b0;
      bus.LevelOut <= 2'd0;
      bus.ShowDigit <= 4'd0;
      bus.ShowValid <= 1'b0;
      bus.Busy <= 1'b0;
      bus.Win <= 1'b0;
      bus.Lose <= 1'b0;
      bus.Score <= 8'd0;
    end else begin
      bus.Win <= 1'b0;
      bus.Lose <= 1'b0;
      case (state)
        IDLE: if (bus.Start) begin
          state <= FILL;
          idx <= '0;
          tcnt <= '0;
          bus.LevelOut <= lvl;
          last <= lvl == 2'd0 ? IW'(3) : lvl == 2'd1 ? IW'(5) : IW'(7);
          bus.RandEnable <= 1'b1;
          bus.Busy <= 1'b1;
        end
        FILL: begin
          digits[idx] <= bus.RandIn;
          idx <= idx + 1'b1;
          if (idx == last) begin
            state <= SHOW;
            idx <= '0;
            tcnt <= '0;
            bus.RandEnable <= 1'b0;
            bus.ShowValid <= 1'b1;
            bus.ShowDigit <= digits[0];
          end
        end
        SHOW: if (bus.Tick) begin
          if (tcnt == TW'(SHOW_TICKS - 1)) begin
            tcnt <= '0;
            if (idx == last) begin
              state <= INPUT;
              idx <= '0;
              bus.ShowValid <= 1'b0;
              bus.ShowDigit <= 4'd0;
            end else begin
              idx <= idx + 1'b1;
              bus.ShowDigit <= digits[idx + 1'b1];
            end
          end else tcnt <= tcnt + 1'b1;
        end
        INPUT: begin
          // a guess takes precedence over a coincident Tick, so it can rescue the last timeout slot
          if (bus.GuessValid) begin
            if (bus.Guess == digits[idx]) begin
              tcnt <= '0;
              idx <= idx + 1'b1;
              if (idx == last) begin
                state <= WIN;
                bus.Win <= 1'b1;
                bus.Score <= bus.Score == 8'd255 ? bus.Score : bus.Score + 8'd1;
              end
            end else begin
              state <= LOSE;
              bus.Lose <= 1'b1;
            end
          end else if (bus.Tick) begin
            if (tcnt == TW'(INPUT_TICKS - 1)) begin
              state <= LOSE;
              bus.Lose <= 1'b1;
            end else tcnt <= tcnt + 1'b1;
          end
        end
        WIN, LOSE: begin
          state <= IDLE;
          idx <= '0;
          tcnt <= '0;
          bus.Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
